wrr_pop_sched: RTL and testbench
================================

# wrr_pop_sched

Weighted round-robin pop scheduler that drains four input FIFOs into one downstream consumer. Each queue gets a programmable burst quantum; the block walks the queues in fixed order 0→1→2→3→0. It pops up to the quantum from each non-empty queue, skips empty or disabled queues, and stalls on downstream back-pressure. It sits between the per-class FIFO bank and the shared output path, and drives the FIFO pop strobes directly.

## Interface
- No parameters: 4 queues, 3-bit weights, fixed.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-low; sampled on posedge clk.
- `weight` in 12: per-queue quantum, queue i at [3i+2:3i]. Range 0–7; 0 = queue disabled. Sampled live.
- `empty` in 4: FIFO empty flags, bit i = queue i. Valid in the same cycle.
- `out_af` in 1: downstream almost-full; 1 = no pop allowed this cycle.
- `pop` out 4: one-hot pop strobe to FIFO i; the FIFO consumes on the same posedge.
- `pop_id` out 2: current queue pointer; identifies the popped queue when valid=1.
- `valid` out 1: 1 = a pop occurs this cycle (equals |pop).

## Operation
- Registered state:
  - `cur` (2b): queue pointer.
  - `credit` (3b): pops remaining in the burst.
  - `st`: SCAN or SERVE.
- Outputs are combinational from the registered state and the current inputs (Mealy). This ensures `empty` is never stale after a pop.
- `elig` is defined per state:
  - SCAN: `weight[cur]!=0 && !empty[cur] && !out_af`.
  - SERVE: `!empty[cur] && !out_af`. Weight is ignored once a burst starts.
- `valid=elig`, `pop=elig ? (1<<cur) : 0`, `pop_id=cur`.
- SCAN transitions:
  - `out_af=1`: hold everything.
  - `weight[cur]==0` or `empty[cur]=1` (and `out_af=0`): `cur<=cur+1` (wraps 3→0), stay SCAN, no pop.
  - elig and `weight[cur]==1`: pop, `cur<=cur+1`, stay SCAN.
  - elig and `weight[cur]>1`: pop, `credit<=weight[cur]-1`, go SERVE.
- SERVE transitions:
  - `out_af=1`: hold `cur`, `credit` and `st`; no pop.
  - `empty[cur]=1`: forfeit remaining credit, `cur<=cur+1`, go SCAN, no pop.
  - Otherwise pop, `credit<=credit-1`. If `credit==1`: `cur<=cur+1`, `credit<=0`, go SCAN.
- Weight changes take effect at the next SCAN load of that queue. An in-flight burst is unaffected.
- Reset (`reset=0` at posedge): `cur<=0`, `credit<=0`, `st<=SCAN`. While `reset=0` the outputs are forced to `pop=0`, `valid=0`, `pop_id=0`, regardless of inputs.
- Asserting reset mid-burst aborts the burst; no pop is issued in a cycle where `reset=0`.

## Timing
- Pop latency: 0 cycles. `pop` is asserted in the same cycle its conditions hold, and the FIFO consumes it at the ending posedge.
- Maximum throughput is 1 pop/cycle. A burst of weight W takes W consecutive cycles with no gaps when `out_af=0` and the queue stays non-empty.
- Each skipped queue (empty or weight 0) costs exactly 1 idle cycle. An early-empty exit in SERVE costs 1 idle cycle.
- Full-rotation bound: sum(weights) + 4 cycles.
- All queues empty or disabled: `cur` cycles 0,1,2,3,… one step per cycle, and `valid` stays 0.
- `out_af` is honored the same cycle: no pop in any cycle with `out_af=1`. The pointer and credit freeze during back-pressure.
- First possible pop is the first cycle with `reset=1`, using `cur=0`.

## Test plan
- **Reset:** hold `reset=0` for 3 cycles with `empty=4'h0`, `weight=12'o1111`. Required: `pop=0`, `valid=0`, `pop_id=0` throughout. The first cycle with `reset=1` gives `pop=4'b0001`.
- **Weighted rotation:** weights q0..q3 = 1,2,3,1 (`weight=12'b001_011_010_001`), `empty=0`, `out_af=0`. Required: `pop_id` sequence 0,1,1,2,2,2,3,0,1,… with `valid=1` every cycle (period 7).
- **Skip:** all weights 2, `empty=4'b0010`. Required: 0,0,(idle, `pop_id=1`, `valid=0`),2,2,3,3,0,0 (period 7).
- **Early empty:** `weight[0]=4`; raise `empty[0]` after 2 pops of q0. Required: 2 pops of q0, then 1 cycle `valid=0`, then the q1 burst starts.
- **Back-pressure:** all weights 3; assert `out_af` for 3 cycles after the first q1 pop. Required: `valid=0` and `pop_id=1` held for 3 cycles, then exactly 2 more q1 pops, then q2.
- **Reset mid-burst:** all weights 7; pull `reset=0` after the 3rd q0 pop for 1 cycle. Required: no pop in the reset cycle, then a fresh 7-pop burst on q0.

Source files
------------

// File: rtl/wrr_pop_sched.sv
// Weighted round-robin pop scheduler: drains four FIFOs in order 0..3, popping up to
// a per-queue quantum each visit. Outputs are Mealy so pops react to same-cycle empty/out_af.
module wrr_pop_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] weight,
  input  logic [3:0]  empty,
  input  logic        out_af,
  output logic [3:0]  pop,
  output logic [1:0]  pop_id,
  output logic        valid
);

  typedef enum logic {SCAN, SERVE} st_t;

  st_t            st, st_n;
  logic [1:0]     cur, cur_n;
  logic [2:0]     credit, credit_n;
  logic [3:0][2:0] wq;
  logic [2:0]     w;
  logic           emp;
  logic           elig;

  assign wq  = weight;
  assign w   = wq[cur];
  assign emp = empty[cur];

  always_ff @(posedge clk) begin
    if (!reset) begin
      st     <= SCAN;
      cur    <= 2'd0;
      credit <= 3'd0;
    end else begin
      st     <= st_n;
      cur    <= cur_n;
      credit <= credit_n;
    end
  end

  always_comb begin
    elig     = 1'b0;
    st_n     = st;
    cur_n    = cur;
    credit_n = credit;
    // elig stays low under reset, which forces pop/valid to zero.
    if (reset && !out_af) begin
      case (st)
        SCAN: begin
          if (w == 3'd0 || emp) begin
            cur_n = cur + 2'd1;
          end else begin
            elig = 1'b1;
            if (w == 3'd1) begin
              cur_n = cur + 2'd1;
            end else begin
              credit_n = w - 3'd1;
              st_n     = SERVE;
            end
          end
        end
        SERVE: begin
          if (emp) begin
            // Queue ran dry mid-burst: drop the leftover credit and move on.
            cur_n    = cur + 2'd1;
            credit_n = 3'd0;
            st_n     = SCAN;
          end else begin
            elig     = 1'b1;
            credit_n = credit - 3'd1;
            if (credit == 3'd1) begin
              cur_n = cur + 2'd1;
              st_n  = SCAN;
            end
          end
        end
        default: st_n = SCAN;
      endcase
    end
  end

  assign valid  = elig;
  assign pop    = elig ? (4'b0001 << cur) : 4'b0000;
  assign pop_id = reset ? cur : 2'd0;

endmodule

// File: tb/tb_wrr_pop_sched.sv
// Randomized + directed bench for wrr_pop_sched; a queue-level burst model predicts
// each cycle's outputs and a decoupled monitor compares them against the DUT.
module tb_wrr_pop_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] weight;
  logic [3:0]  empty;
  logic        out_af;
  logic [3:0]  pop;
  logic [1:0]  pop_id;
  logic        valid;

  wrr_pop_sched dut (
    .clk(clk), .reset(reset), .weight(weight), .empty(empty),
    .out_af(out_af), .pop(pop), .pop_id(pop_id), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] p;
    logic [1:0] id;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;

  // Model state: which queue is being visited and how many pops of its burst remain
  // (0 means the queue has not been granted yet on this visit).
  int   mq = 0;
  int   mleft = 0;

  function automatic int qweight(input logic [11:0] wv, input int q);
    return int'((wv >> (3 * q)) & 12'h7);
  endfunction

  task automatic drive(input logic r, input logic [11:0] wv, input logic [3:0] e, input logic af);
    exp_t x;
    @(posedge clk);
    #1;
    reset = r; weight = wv; empty = e; out_af = af;
    cycle++;
    x.v = 1'b0; x.p = 4'b0; x.id = 2'(mq); x.cyc = cycle;
    if (!r) begin
      x.id = 2'd0;
      mq = 0; mleft = 0;
    end else if (!af) begin
      if (mleft == 0) begin
        int wq;
        wq = qweight(wv, mq);
        if (wq == 0 || e[mq]) begin
          mq = (mq + 1) % 4;
        end else begin
          x.v = 1'b1;
          mleft = wq - 1;
          if (mleft == 0) mq = (mq + 1) % 4;
        end
      end else begin
        if (e[mq]) begin
          mleft = 0;
          mq = (mq + 1) % 4;
        end else begin
          x.v = 1'b1;
          mleft--;
          if (mleft == 0) mq = (mq + 1) % 4;
        end
      end
    end
    if (x.v) x.p = 4'(1 << x.id);
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      vectors++;
      if (valid !== x.v || pop !== x.p || pop_id !== x.id) begin
        miscompares++;
        $display("FAIL outputs cycle %0d: got valid=%b pop=%b pop_id=%0d, want valid=%b pop=%b pop_id=%0d",
                 x.cyc, valid, pop, pop_id, x.v, x.p, x.id);
      end
    end
  end

  initial begin
    logic [11:0] rw;
    reset = 1'b0; weight = 12'o1111; empty = 4'h0; out_af = 1'b0;

    // Reset held, then first live cycle pops q0.
    repeat (3) drive(1'b0, 12'o1111, 4'h0, 1'b0);
    repeat (4) drive(1'b1, 12'o1111, 4'h0, 1'b0);

    // Weighted rotation 1,2,3,1.
    drive(1'b0, 12'b001_011_010_001, 4'h0, 1'b0);
    repeat (14) drive(1'b1, 12'b001_011_010_001, 4'h0, 1'b0);

    // Skip empty q1.
    drive(1'b0, 12'o2222, 4'b0010, 1'b0);
    repeat (14) drive(1'b1, 12'o2222, 4'b0010, 1'b0);

    // Early empty on q0 after two pops.
    drive(1'b0, 12'o1114, 4'h0, 1'b0);
    repeat (2) drive(1'b1, 12'o1114, 4'h0, 1'b0);
    repeat (4) drive(1'b1, 12'o1114, 4'b0001, 1'b0);

    // Back-pressure after first q1 pop.
    drive(1'b0, 12'o3333, 4'h0, 1'b0);
    repeat (4) drive(1'b1, 12'o3333, 4'h0, 1'b0);
    repeat (3) drive(1'b1, 12'o3333, 4'h0, 1'b1);
    repeat (4) drive(1'b1, 12'o3333, 4'h0, 1'b0);

    // Reset mid-burst.
    drive(1'b0, 12'o7777, 4'h0, 1'b0);
    repeat (3) drive(1'b1, 12'o7777, 4'h0, 1'b0);
    drive(1'b0, 12'o7777, 4'h0, 1'b0);
    repeat (8) drive(1'b1, 12'o7777, 4'h0, 1'b0);

    // All disabled: pointer walks, never valid.
    repeat (6) drive(1'b1, 12'o0000, 4'h0, 1'b0);

    // Random traffic with live weight changes.
    rw = 12'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) rw = 12'($urandom);
      drive(($urandom_range(0, 49) != 0), rw,
            4'($urandom) & 4'($urandom),
            ($urandom_range(0, 3) == 0));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
